// File: rtl/nios_system_com_mem_arbiter_if.sv
// nios_system_com_mem_arbiter_if
//
// Purpose: Avalon-MM requester bundle for one port of the communication
// memory arbiter. There is one instance per requester.
//
// Signals:
//   address       word address (ADDR_W)
//   byteenable    byte lanes (DATA_W/8)
//   read, write   request strobes (never both high in one cycle)
//   writedata     write data (DATA_W)
//   waitrequest   high = request not accepted this cycle
//   readdata      read data, qualified by readdatavalid
//   readdatavalid one-cycle read-return strobe
//
// Modports:
//   master  requester side (drives the request)
//   slave   arbiter side (drives waitrequest and the read return)
interface nios_system_com_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/nios_system_com_mem_arbiter.sv
// nios_system_com_mem_arbiter
//
// Purpose: shares the single-port 256x32 communication memory between the
// Nios II data master (port 0) and the radio DMA engine (port 1). At most one
// access is accepted per cycle. Writes complete on the accept edge. Reads
// return exactly one cycle after the accept edge, to the issuing port only.
//
// Build option:
//   COM_ARB_RR_EN  defined   -> round-robin on contention (grant the port
//                               that did not win last time)
//                  undefined -> fixed priority, port 0 wins contention
//
// Ports:
//   clk             single clock for the arbiter and the memory
//   reset_n         asynchronous, active-low reset
//   m0, m1          requester ports (interface, slave modport)
//   mem_address     memory word address (holds its last value when idle)
//   mem_byteenable  memory byte lanes
//   mem_chipselect  memory select, high on an accepted access
//   mem_write       memory write strobe
//   mem_writedata   memory write data
//   mem_clken       memory clock enable, high whenever reset_n is high
//   mem_readdata    memory read data, valid the cycle after the address
module nios_system_com_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nios_system_com_mem_arbiter_if.slave m0,
    nios_system_com_mem_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);
    localparam int BE_W = DATA_W / 8;

    logic              req0;
    logic              req1;
    logic              accept;
    logic              winner;     // 0 = port 0, 1 = port 1

    logic              last_grant_q, last_grant_d;
    logic              rd_pending_q, rd_pending_d;
    logic              rd_owner_q,   rd_owner_d;
    logic [ADDR_W-1:0] addr_hold_q,  addr_hold_d;
    logic [BE_W-1:0]   be_hold_q,    be_hold_d;
    logic [DATA_W-1:0] wdata_hold_q, wdata_hold_d;

    always_comb begin
        req0   = m0.read | m0.write;
        req1   = m1.read | m1.write;
        // Nothing is accepted while reset is asserted, so waitrequest stays
        // high and the memory sees no access even if requests are present.
        accept = reset_n & (req0 | req1);

        if (req0 && req1) begin
`ifdef COM_ARB_RR_EN
            winner = ~last_grant_q;
`else
            winner = 1'b0;
`endif
        end else begin
            winner = req1;
        end
    end

    always_comb begin
        mem_chipselect = accept;
        mem_write      = 1'b0;
        mem_address    = addr_hold_q;
        mem_byteenable = be_hold_q;
        mem_writedata  = wdata_hold_q;
        if (accept) begin
            if (winner) begin
                mem_write      = m1.write;
                mem_address    = m1.address;
                mem_byteenable = m1.byteenable;
                mem_writedata  = m1.writedata;
            end else begin
                mem_write      = m0.write;
                mem_address    = m0.address;
                mem_byteenable = m0.byteenable;
                mem_writedata  = m0.writedata;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        rd_pending_d = 1'b0;
        rd_owner_d   = rd_owner_q;
        addr_hold_d  = mem_address;
        be_hold_d    = mem_byteenable;
        wdata_hold_d = mem_writedata;
        if (accept) begin
            last_grant_d = winner;
            if (!mem_write) begin
                rd_pending_d = 1'b1;
                rd_owner_d   = winner;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
            addr_hold_q  <= '0;
            be_hold_q    <= '0;
            wdata_hold_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
            addr_hold_q  <= addr_hold_d;
            be_hold_q    <= be_hold_d;
            wdata_hold_q <= wdata_hold_d;
        end
    end

    assign m0.waitrequest   = ~(accept & ~winner);
    assign m1.waitrequest   = ~(accept & winner);

    // Read data is shared; only readdatavalid tells a port the data is its own.
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;
    assign m0.readdatavalid = rd_pending_q & ~rd_owner_q;
    assign m1.readdatavalid = rd_pending_q & rd_owner_q;

    assign mem_clken        = reset_n;
endmodule

// File: tb/tb_nios_system_com_mem_arbiter.sv
`timescale 1ns/1ps
module tb_nios_system_com_mem_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
`ifdef COM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nios_system_com_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    nios_system_com_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata = '0;

    nios_system_com_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0_if),
        .m1             (m1_if),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    // Behavioural single-port RAM with registered read data.
    logic [DATA_W-1:0] ram [256];
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < BE_W; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            mem_readdata <= ram[mem_address];
        end
    end

    // Reference model state.
    logic [DATA_W-1:0] mdl_mem [256];
    bit                exp_last;
    bit                exp_pend;
    bit                exp_owner;
    logic [DATA_W-1:0] exp_rdata;
    logic [ADDR_W-1:0] exp_addr_h;
    logic [BE_W-1:0]   exp_be_h;
    logic [DATA_W-1:0] exp_wd_h;

    int n_checks = 0;
    int n_pass   = 0;
    bit acc0, acc1;
    int ret0, ret1;
    logic [DATA_W-1:0] q0 [$];
    logic [DATA_W-1:0] q1 [$];

    task automatic model_reset();
        exp_last   = 1'b1;
        exp_pend   = 1'b0;
        exp_owner  = 1'b0;
        exp_addr_h = '0;
        exp_be_h   = '0;
        exp_wd_h   = '0;
    endtask

    task automatic clear_returns();
        ret0 = 0;
        ret1 = 0;
        q0.delete();
        q1.delete();
    endtask

    task automatic set_port(input int p, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                            input logic [BE_W-1:0] be, input logic [DATA_W-1:0] wd);
        if (p == 0) begin
            m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
            m0_if.byteenable = be; m0_if.writedata = wd;
        end else begin
            m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
            m1_if.byteenable = be; m1_if.writedata = wd;
        end
    endtask

    task automatic idle_ports();
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ram[a]     = d;
        mdl_mem[a] = d;
    endtask

    // One clock cycle: called at a falling edge with inputs already driven.
    // Predicts the cycle from the arbitration rules, compares, then advances
    // the model across the rising edge and returns at the next falling edge.
    task automatic step();
        bit r0, r1, any, w, ewr;
        logic [ADDR_W-1:0] ea;
        logic [BE_W-1:0]   eb;
        logic [DATA_W-1:0] ew;
        #1;
        r0  = m0_if.read | m0_if.write;
        r1  = m1_if.read | m1_if.write;
        any = r0 | r1;
        if (r0 && r1) w = RR ? !exp_last : 1'b0;
        else          w = r1;
        acc0 = any && !w;
        acc1 = any && w;
        if (any) begin
            ea  = w ? m1_if.address    : m0_if.address;
            eb  = w ? m1_if.byteenable : m0_if.byteenable;
            ew  = w ? m1_if.writedata  : m0_if.writedata;
            ewr = w ? m1_if.write      : m0_if.write;
        end else begin
            ea = exp_addr_h; eb = exp_be_h; ew = exp_wd_h; ewr = 1'b0;
        end

        n_checks++; if (m0_if.waitrequest !== !acc0) $display("FAIL wait0 t=%0t got %b exp %b", $time, m0_if.waitrequest, !acc0); else n_pass++;
        n_checks++; if (m1_if.waitrequest !== !acc1) $display("FAIL wait1 t=%0t got %b exp %b", $time, m1_if.waitrequest, !acc1); else n_pass++;
        n_checks++; if (mem_chipselect !== any) $display("FAIL chipselect t=%0t got %b exp %b", $time, mem_chipselect, any); else n_pass++;
        n_checks++; if (mem_write !== ewr) $display("FAIL mem_write t=%0t got %b exp %b", $time, mem_write, ewr); else n_pass++;
        n_checks++; if (mem_address !== ea) $display("FAIL mem_address t=%0t got %h exp %h", $time, mem_address, ea); else n_pass++;
        n_checks++; if (mem_byteenable !== eb) $display("FAIL mem_byteenable t=%0t got %h exp %h", $time, mem_byteenable, eb); else n_pass++;
        n_checks++; if (mem_writedata !== ew) $display("FAIL mem_writedata t=%0t got %h exp %h", $time, mem_writedata, ew); else n_pass++;
        n_checks++; if (mem_clken !== 1'b1) $display("FAIL mem_clken t=%0t got %b exp 1", $time, mem_clken); else n_pass++;
        n_checks++; if (m0_if.readdatavalid !== (exp_pend && !exp_owner)) $display("FAIL rdv0 t=%0t got %b exp %b", $time, m0_if.readdatavalid, exp_pend && !exp_owner); else n_pass++;
        n_checks++; if (m1_if.readdatavalid !== (exp_pend && exp_owner)) $display("FAIL rdv1 t=%0t got %b exp %b", $time, m1_if.readdatavalid, exp_pend && exp_owner); else n_pass++;
        if (exp_pend) begin
            if (exp_owner) begin
                n_checks++; if (m1_if.readdata !== exp_rdata) $display("FAIL rdata1 t=%0t got %h exp %h", $time, m1_if.readdata, exp_rdata); else n_pass++;
            end else begin
                n_checks++; if (m0_if.readdata !== exp_rdata) $display("FAIL rdata0 t=%0t got %h exp %h", $time, m0_if.readdata, exp_rdata); else n_pass++;
            end
        end
        if (m0_if.readdatavalid === 1'b1) begin ret0++; q0.push_back(m0_if.readdata); end
        if (m1_if.readdatavalid === 1'b1) begin ret1++; q1.push_back(m1_if.readdata); end

        @(posedge clk);
        exp_pend = 1'b0;
        if (any) begin
            exp_last   = w;
            exp_addr_h = ea;
            exp_be_h   = eb;
            exp_wd_h   = ew;
            if (ewr) begin
                for (int b = 0; b < BE_W; b++)
                    if (eb[b]) mdl_mem[ea][8*b +: 8] = ew[8*b +: 8];
            end else begin
                exp_pend  = 1'b1;
                exp_owner = w;
                exp_rdata = mdl_mem[ea];
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++; if (m0_if.waitrequest !== 1'b1) $display("FAIL %s wait0 got %b exp 1", tag, m0_if.waitrequest); else n_pass++;
        n_checks++; if (m1_if.waitrequest !== 1'b1) $display("FAIL %s wait1 got %b exp 1", tag, m1_if.waitrequest); else n_pass++;
        n_checks++; if (m0_if.readdatavalid !== 1'b0) $display("FAIL %s rdv0 got %b exp 0", tag, m0_if.readdatavalid); else n_pass++;
        n_checks++; if (m1_if.readdatavalid !== 1'b0) $display("FAIL %s rdv1 got %b exp 0", tag, m1_if.readdatavalid); else n_pass++;
        n_checks++; if ({mem_chipselect, mem_write, mem_clken} !== 3'b000) $display("FAIL %s cs/wr/clken got %b exp 000", tag, {mem_chipselect, mem_write, mem_clken}); else n_pass++;
        n_checks++; if (mem_address !== '0) $display("FAIL %s mem_address got %h exp 0", tag, mem_address); else n_pass++;
        n_checks++; if (mem_byteenable !== '0) $display("FAIL %s mem_byteenable got %h exp 0", tag, mem_byteenable); else n_pass++;
        n_checks++; if (mem_writedata !== '0) $display("FAIL %s mem_writedata got %h exp 0", tag, mem_writedata); else n_pass++;
    endtask

    task automatic test_reset();
        // Requests present during reset must not be accepted.
        set_port(0, 1'b1, 1'b0, 8'h10, 4'hF, 32'h1);
        set_port(1, 1'b0, 1'b1, 8'h20, 4'hF, 32'h2);
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        idle_ports();
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        step();
    endtask

    task automatic test_write_read();
        clear_returns();
        set_port(0, 1'b0, 1'b1, 8'h10, 4'hF, 32'hDEADBEEF);
        step();
        set_port(0, 1'b1, 1'b0, 8'h10, 4'hF, 32'h0);
        step();
        idle_ports();
        step();
        n_checks++; if (q0.size() != 1 || q0[0] !== 32'hDEADBEEF) $display("FAIL write_read q0 size %0d first %h exp 1 deadbeef", q0.size(), (q0.size() > 0) ? q0[0] : 32'h0); else n_pass++;
        n_checks++; if (ret1 != 0) $display("FAIL write_read ret1 got %0d exp 0", ret1); else n_pass++;
    endtask

    task automatic test_byte_lanes();
        clear_returns();
        set_port(0, 1'b0, 1'b1, 8'h20, 4'hF, 32'h11223344);
        step();
        set_port(0, 1'b0, 1'b1, 8'h20, 4'h5, 32'hAABBCCDD);
        step();
        set_port(0, 1'b1, 1'b0, 8'h20, 4'hF, 32'h0);
        step();
        idle_ports();
        step();
        n_checks++; if (q0.size() != 1 || q0[0] !== 32'h11BB33DD) $display("FAIL byte_lanes size %0d data %h exp 1 11bb33dd", q0.size(), (q0.size() > 0) ? q0[0] : 32'h0); else n_pass++;
    endtask

    task automatic test_contention();
        int e0, e1;
        preload(8'h01, 32'hC0DE0001);
        preload(8'h02, 32'hC0DE0002);
        // A lone port-1 access leaves last_grant at port 1.
        set_port(1, 1'b1, 1'b0, 8'h02, 4'hF, 32'h0);
        step();
        idle_ports();
        step();
        clear_returns();
        set_port(0, 1'b1, 1'b0, 8'h01, 4'hF, 32'h0);
        set_port(1, 1'b1, 1'b0, 8'h02, 4'hF, 32'h0);
        repeat (8) step();
        idle_ports();
        step();
        e0 = RR ? 4 : 8;
        e1 = RR ? 4 : 0;
        n_checks++; if (ret0 != e0) $display("FAIL contention ret0 got %0d exp %0d", ret0, e0); else n_pass++;
        n_checks++; if (ret1 != e1) $display("FAIL contention ret1 got %0d exp %0d", ret1, e1); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) preload(ADDR_W'(i), 32'hA0 + DATA_W'(i));
        clear_returns();
        for (int i = 0; i < 4; i++) begin
            set_port(1, 1'b1, 1'b0, ADDR_W'(i), 4'hF, 32'h0);
            step();
        end
        idle_ports();
        step();
        n_checks++; if (q1.size() != 4) $display("FAIL back_to_back count got %0d exp 4", q1.size()); else n_pass++;
        for (int i = 0; i < 4 && i < q1.size(); i++) begin
            n_checks++; if (q1[i] !== 32'hA0 + DATA_W'(i)) $display("FAIL back_to_back data%0d got %h exp %h", i, q1[i], 32'hA0 + DATA_W'(i)); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_read();
        preload(8'h40, 32'h5A5A4040);
        set_port(0, 1'b1, 1'b0, 8'h40, 4'hF, 32'h0);
        step();
        idle_ports();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_read");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        clear_returns();
        step();
        step();
        n_checks++; if (ret0 + ret1 != 0) $display("FAIL mid_read returns got %0d exp 0", ret0 + ret1); else n_pass++;
        set_port(0, 1'b1, 1'b0, 8'h01, 4'hF, 32'h0);
        set_port(1, 1'b1, 1'b0, 8'h02, 4'hF, 32'h0);
        step();
        n_checks++; if ({acc0, acc1} !== 2'b10) $display("FAIL post_reset_grant got %b exp 10", {acc0, acc1}); else n_pass++;
        idle_ports();
        step();
    endtask

    task automatic test_mixed();
        preload(8'h30, 32'h0BAD0030);
        // Lone port-1 access so last_grant = 1 going in.
        set_port(1, 1'b1, 1'b0, 8'h02, 4'hF, 32'h0);
        step();
        clear_returns();
        set_port(0, 1'b1, 1'b0, 8'h30, 4'hF, 32'h0);
        set_port(1, 1'b0, 1'b1, 8'h30, 4'hF, 32'h600D0030);
        step();
        n_checks++; if ({acc0, acc1} !== 2'b10) $display("FAIL mixed first_grant got %b exp 10", {acc0, acc1}); else n_pass++;
        set_port(0, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
        step();
        n_checks++; if (acc1 !== 1'b1) $display("FAIL mixed write_accept got %b exp 1", acc1); else n_pass++;
        set_port(1, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
        set_port(0, 1'b1, 1'b0, 8'h30, 4'hF, 32'h0);
        step();
        idle_ports();
        step();
        n_checks++; if (q0.size() != 2) $display("FAIL mixed count got %0d exp 2", q0.size()); else n_pass++;
        if (q0.size() == 2) begin
            n_checks++; if (q0[0] !== 32'h0BAD0030) $display("FAIL mixed old_data got %h exp 0bad0030", q0[0]); else n_pass++;
            n_checks++; if (q0[1] !== 32'h600D0030) $display("FAIL mixed new_data got %h exp 600d0030", q0[1]); else n_pass++;
        end
    endtask

    task automatic test_random();
        bit busy [2];
        bit acc  [2];
        int kind;
        for (int c = 0; c < 400; c++) begin
            busy[0] = m0_if.read | m0_if.write;
            busy[1] = m1_if.read | m1_if.write;
            acc[0]  = acc0;
            acc[1]  = acc1;
            // Unaccepted requests are held stable; otherwise pick a new one.
            for (int p = 0; p < 2; p++) begin
                if (!busy[p] || acc[p]) begin
                    kind = $urandom_range(0, 9);
                    if (kind < 3)
                        set_port(p, 1'b0, 1'b0, ADDR_W'($urandom_range(0, 7)), '0, '0);
                    else if (kind < 6)
                        set_port(p, 1'b1, 1'b0, ADDR_W'($urandom_range(0, 7)), BE_W'($urandom), '0);
                    else
                        set_port(p, 1'b0, 1'b1, ADDR_W'($urandom_range(0, 7)), BE_W'($urandom), DATA_W'($urandom));
                end
            end
            step();
        end
        idle_ports();
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 32'h0;
            mdl_mem[i] = 32'h0;
        end
        idle_ports();
        model_reset();
        acc0 = 1'b0;
        acc1 = 1'b0;
        clear_returns();
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
        test_mixed();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/nios_system_com_mem_arbiter.md
# nios_system_com_mem_arbiter

Two-port arbiter sharing the 256×32 single-port communication on-chip memory between the Nios II data master (port 0) and the car-control radio DMA engine (port 1). Presents an Avalon-MM slave with waitrequest and readdatavalid to each requester. Drives the memory's address/byteenable/chipselect/write/writedata/clken inputs and returns its readdata one cycle later to the port that issued the read.

## Interface
- ADDR_W, 8, word address width; memory depth is 2^ADDR_W.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- clk  in  1  single clock for all logic and the memory.
- reset_n  in  1  asynchronous, active-low reset.
- mN_address  in  ADDR_W  port N word address (N = 0, 1).
- mN_byteenable  in  DATA_W/8  port N byte lanes.
- mN_read / mN_write  in  1  port N request; both high in one cycle is illegal.
- mN_writedata  in  DATA_W  port N write data.
- mN_waitrequest  out  1  high = request not accepted this cycle.
- mN_readdata  out  DATA_W  port N read data, valid when mN_readdatavalid is high.
- mN_readdatavalid  out  1  one-cycle read-return strobe.
- mem_address  out  ADDR_W  to memory address.
- mem_byteenable  out  DATA_W/8  to memory byteenable.
- mem_chipselect / mem_write  out  1  to memory.
- mem_writedata  out  DATA_W  to memory.
- mem_clken  out  1  memory clock enable.
- mem_readdata  in  DATA_W  from memory; valid the cycle after the address is presented.

## Operation
- Request: reqN = mN_read | mN_write. At most one request is accepted per cycle.
- Grant is combinational from reqN and the registered last_grant: with both requesting, the winner is chosen by the configured policy (see Configuration); with one requesting, that port wins.
- Winning port: mN_waitrequest = 0. Its address, byteenable, writedata and write are muxed onto mem_*, with mem_chipselect = 1. The losing or idle port sees mN_waitrequest = 1.
- No request: mem_chipselect = 0, mem_write = 0; mem_address holds its previous value.
- Write completes in the accept cycle. No readdatavalid is generated for a write.
- Read accepted in cycle N:
  - Register rd_pending = 1 and rd_owner = N.
  - In cycle N+1, assert readdatavalid for rd_owner only, with readdata = mem_readdata.
- Reads are pipelined: a new request (either port) can be accepted in the same cycle as a read return.
- mN_readdata is driven from mem_readdata for both ports. Only readdatavalid qualifies it.
- last_grant updates to the winner on every accepted request and holds otherwise.
- mem_clken is 1 whenever reset_n is high.

## Timing
- Reset (reset_n low, asynchronous):
  - last_grant = 1.
  - rd_pending = 0, rd_owner = 0.
  - m0/m1_readdatavalid = 0.
  - m0/m1_waitrequest = 1.
  - mem_chipselect = 0, mem_write = 0, mem_clken = 0.
  - mem_address = 0, mem_byteenable = 0, mem_writedata = 0.
  - mN_readdata follows mem_readdata and has no reset value.
- Waitrequest stays high while reset_n is low and is combinational afterwards.
- Accept-to-write latency: 0 cycles, the memory captures the write on the accept edge.
- Read latency: exactly 1 cycle from the accept edge to readdatavalid. No variable latency.
- Throughput: 1 access per cycle aggregate.
- Reset asserted with a read in flight: the pending readdatavalid is dropped and no return is generated after reset.
- A requester held in waitrequest must keep its request stable; the arbiter does not register unaccepted requests.

## Configuration
- COM_ARB_RR_EN defined: round-robin. On contention, grant the port ≠ last_grant. Continuous contention alternates 0,1,0,1… and no port starves.
- COM_ARB_RR_EN undefined: fixed priority. Port 0 always wins contention and port 1 is served only when req0 = 0. last_grant is still maintained but does not affect the decision.

## Test plan
- Reset release, port 0 write 0xDEADBEEF to 0x10 with byteenable 0xF, then read 0x10 → m0_waitrequest=0 on both; m0_readdatavalid one cycle after the read accept with 0xDEADBEEF; m1_readdatavalid stays 0.
- Byte lanes: write 0x11223344 to 0x20, then write 0xAABBCCDD with byteenable 0x5, then read 0x20 → 0x11BB33DD.
- Contention: both ports request reads every cycle, 8 cycles, m0 at 0x01, m1 at 0x02 → with COM_ARB_RR_EN, grants alternate starting with port 0, giving 4 returns each with no gaps; without the macro, 8 returns to port 0 and m1_waitrequest stays 1.
- Back-to-back pipelined reads: port 1 reads 0x00..0x03 on consecutive cycles (memory preloaded with 0xA0..0xA3) → m1_readdatavalid high for 4 consecutive cycles carrying 0xA0..0xA3 in order.
- Reset mid-read: assert reset_n low in the cycle after a read accept → no readdatavalid on either port; all outputs at their reset values; the first post-reset contention goes to port 0.
- Mixed: port 0 reads 0x30 while port 1 writes 0x30 in the same cycle (round-robin, last_grant=1) → the read is served first and returns the old data; the write is accepted the next cycle; a subsequent read returns the new data.
